// File: rtl/mult_operand_feeder.sv
// Frame-aligned operand sequencer and 2-entry result queue for the 16x16 sequential multiplier.
// Optional saturating activity counters are compiled in when MULT_FEEDER_STATS_EN is defined.
module mult_operand_feeder #(
   parameter int WIDTH = 16,
   parameter int FRAME = 32,
   parameter int DEPTH = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic [WIDTH-1:0]   Multiplicando,
   output logic [WIDTH-1:0]   Multiplicador,
   output logic [WIDTH-1:0]   MultiplicandoReg,
   output logic               Sy,
   input  logic [2*WIDTH-1:0] Produto,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_data,
`ifdef MULT_FEEDER_STATS_EN
   output logic [15:0]        ops_issued,
   output logic [15:0]        idle_frames,
`endif
   output logic               busy
);
   localparam int SW = $clog2(FRAME);
   localparam int PW = $clog2(DEPTH);

   logic [SW-1:0]      slot;
   logic [WIDTH-1:0]   fifo_a [DEPTH];
   logic [WIDTH-1:0]   fifo_b [DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [PW:0]        fifo_cnt;
   logic [2*WIDTH-1:0] rq_mem [2];
   logic               rq_wr, rq_rd;
   logic [1:0]         rq_cnt;
   logic               cur_inflight, next_inflight;

   logic               prep, load, push, issue, capture, res_pop;
   logic [1:0]         rq_committed;

   // NOTE: combinational logic uses blocking '=', flops use non-blocking '<='.
   always_comb begin
      prep    = Sy && (slot == SW'(FRAME-2));
      load    = Sy && (slot == SW'(FRAME-1));
      push    = in_valid && in_ready;
      res_pop = res_valid && res_ready;
      capture = load && cur_inflight;
      // The product still in flight lands in the queue before this issue does,
      // so it counts against the two slots.
      rq_committed = rq_cnt - {1'b0, res_pop} + {1'b0, cur_inflight};
      issue   = prep && (fifo_cnt != '0) && (rq_committed <= 2'd1);
   end

   assign in_ready  = Sy && (fifo_cnt != (PW+1)'(DEPTH));
   assign res_valid = (rq_cnt != 2'd0);
   assign res_data  = res_valid ? rq_mem[rq_rd] : '0;
   assign busy      = (fifo_cnt != '0) || cur_inflight || next_inflight || res_valid;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         Sy               <= 1'b0;
         slot             <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_cnt         <= '0;
         rq_wr            <= 1'b0;
         rq_rd            <= 1'b0;
         rq_cnt           <= '0;
         cur_inflight     <= 1'b0;
         next_inflight    <= 1'b0;
         Multiplicando    <= '0;
         Multiplicador    <= '0;
         MultiplicandoReg <= '0;
      end else begin
         Sy <= 1'b1;
         if (Sy) slot <= slot + SW'(1);
         if (push)  wr_ptr <= wr_ptr + PW'(1);
         if (issue) rd_ptr <= rd_ptr + PW'(1);
         fifo_cnt <= fifo_cnt + (PW+1)'(push) - (PW+1)'(issue);
         if (prep) begin
            next_inflight <= issue;
            if (issue) begin
               Multiplicando    <= fifo_a[rd_ptr];
               Multiplicador    <= fifo_b[rd_ptr];
               MultiplicandoReg <= fifo_a[rd_ptr];
            end else begin
               Multiplicando <= '0;
               Multiplicador <= '0;
            end
         end
         if (load)    cur_inflight <= next_inflight;
         if (capture) rq_wr <= ~rq_wr;
         if (res_pop) rq_rd <= ~rq_rd;
         rq_cnt <= rq_cnt + 2'(capture) - 2'(res_pop);
      end
   end

   // NOTE: storage arrays are not reset; the occupancy counters alone define valid entries.
   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_a[wr_ptr] <= in_a;
         fifo_b[wr_ptr] <= in_b;
      end
      if (capture) rq_mem[rq_wr] <= Produto;
   end

`ifdef MULT_FEEDER_STATS_EN
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         ops_issued  <= '0;
         idle_frames <= '0;
      end else if (prep) begin
         if (issue) begin
            if (ops_issued != '1) ops_issued <= ops_issued + 16'd1;
         end else if (idle_frames != '1) begin
            idle_frames <= idle_frames + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/mult_operand_feeder.md
Name: mult_operand_feeder

Overview:
- Upstream sequencer for the 16x16 sequential multiplier (`Multiplicador`).
- Buffers operand pairs from a valid/ready producer and generates `Sy`.
- Presents operands on the multiplier's fixed 32-cycle frame and holds `MultiplicandoReg` for the whole frame.
- Captures each finished `Produto` into a small result queue with valid/ready output, so the free-running multiplier can be used as a streaming unit.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH.
- FRAME, 32, cycles per multiplier frame (power of 2).
- DEPTH, 4, operand FIFO depth (power of 2, >=2).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  operand FIFO not full.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- Multiplicando  out  WIDTH  to multiplier, sampled at load edge.
- Multiplicador  out  WIDTH  to multiplier, sampled at load edge.
- MultiplicandoReg  out  WIDTH  multiplicand held for whole frame.
- Sy  out  1  frame sync/start to multiplier.
- Produto  in  2*WIDTH  multiplier product.
- res_valid  out  1  result queue non-empty.
- res_ready  in  1  consumer accepts result.
- res_data  out  2*WIDTH  head of result queue.
- busy  out  1  FIFO non-empty or op in flight or result pending.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low.
  - Reset low at a rising edge: all outputs 0 (`in_ready`=0 during reset).
  - Slot counter 0; both queues empty; inflight flags 0.
- `Sy` timing:
  - `Sy` is registered; it rises on the first edge with Reset high and stays 1.
- Slot counter (log2 FRAME bits):
  - Increments on every edge while `Sy`=1; wraps FRAME-1 -> 0.
  - Slot 0 is the first cycle with `Sy`=1, which aligns it with the multiplier's internal counter.
- Prep edge (slot == FRAME-2):
  - Issue is allowed if the operand FIFO is non-empty and result-queue occupancy after this edge is <=1.
  - On issue: pop FIFO; `Multiplicando` <= a, `Multiplicador` <= b, `MultiplicandoReg` <= a; `next_inflight` <= 1.
  - Otherwise (idle frame): `Multiplicando` and `Multiplicador` <= 0, `MultiplicandoReg` unchanged, `next_inflight` <= 0.
- Load edge (slot == FRAME-1):
  - The multiplier loads the operands on this edge.
  - If `cur_inflight`=1, the feeder pushes `Produto` (the completed previous product) into the result queue.
  - Then `cur_inflight` <= `next_inflight`.
  - The occupancy rule guarantees capture never overflows the queue.
- Hold rule:
  - `MultiplicandoReg` must not change between load edges except at a prep edge.
  - `Multiplicando` may change freely after the load edge.
- Operand FIFO:
  - `in_ready` = !full.
  - Push when `in_valid && in_ready`.
  - Push and pop on the same edge are both honoured.
- Result queue:
  - Depth 2; `res_valid` = non-empty; `res_data` = head.
  - Pop on `res_valid && res_ready`.
  - Capture and pop on the same edge are both honoured.
  - `res_data` is stable while `res_valid && !res_ready`.
- Latency:
  - Operand accepted while idle: issued at the next prep edge.
  - `res_valid` rises one cycle after the load edge FRAME cycles after its own load edge.
  - Minimum latency is FRAME+2 cycles; throughput is 1 op per FRAME cycles.
- Arithmetic: full unsigned 2*WIDTH product, no truncation; FFFF*FFFF = FFFE0001.
- Reset mid-operation: in-flight ops and queued data are discarded; `Sy` drops and resync restarts at slot 0.

Optional Feature:
- Macro: MULT_FEEDER_STATS_EN.
- Defined:
  - Adds outputs `ops_issued` [15:0] and `idle_frames` [15:0], both saturating and cleared by Reset.
  - `ops_issued` increments on each issue; `idle_frames` increments on each non-issuing prep edge while `Sy`=1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset low 2 cycles, then high -> all outputs 0 during reset; `Sy`=1 after the first edge with Reset high; no `res_valid` for 3 frames with no input.
- Push (12,75) at slot 5 -> `Multiplicando`=12, `Multiplicador`=75 and `MultiplicandoReg`=12 after the prep edge; `res_valid`=1 with `res_data`=900 exactly FRAME cycles after the load edge.
- Back-to-back push (16,5), (FFFF,FFFF), (FA1,7D1) with `res_ready`=1 -> results 80, FFFE0001, 7A2971 in order, one per 32 cycles; `MultiplicandoReg` constant within each frame.
- Push 4 pairs with `res_ready`=0 -> exactly 2 results captured; further issues stall (idle frames) and `in_ready` stays 0 once 4 entries are queued; raising `res_ready` drains all 4 correct products in order.
- Assert Reset low mid-frame during an in-flight op -> queues empty, `Sy`=0; after release no stale result appears, and a new op (3,4) returns 12.
- With MULT_FEEDER_STATS_EN defined, 3 ops over 5 frames -> `ops_issued`=3, `idle_frames`=2.
